// File: rtl/sort_ctrl_if.sv
// ---------------------------------------------------------------------------
// sort_ctrl_if
//   Bundles the switch/button inputs, the sort engine handshake and the
//   display outputs of the sort front-end sequencer into one interface.
//
//   Signals:
//     switch       value to enter, sampled on a confirm edge
//     confirm_btn  raw asynchronous push button, active-high
//     eng_busy     engine busy, blocks a new start
//     eng_done     one-cycle pulse, eng_result valid
//     eng_result   sorted values, entry k at [k*W +: W], ascending
//     eng_start    one-cycle start pulse to the engine
//     eng_data     packed collected values, entry k at [k*W +: W]
//     entry_count  values entered so far (0..N)
//     disp_value   nibble currently displayed
//     disp_index   index of the displayed nibble
//     disp_valid   display content valid (SHOW)
//     busy         job in flight (LAUNCH or WAIT)
//     error        engine timed out (FAULT)
//
//   Modports: master = sequencer side, slave = board/engine side.
// ---------------------------------------------------------------------------
interface sort_ctrl_if #(
  parameter int N = 5,
  parameter int W = 4
);
  logic [W-1:0]   switch;
  logic           confirm_btn;
  logic           eng_busy;
  logic           eng_done;
  logic [N*W-1:0] eng_result;
  logic           eng_start;
  logic [N*W-1:0] eng_data;
  logic [2:0]     entry_count;
  logic [W-1:0]   disp_value;
  logic [2:0]     disp_index;
  logic           disp_valid;
  logic           busy;
  logic           error;

  modport master (
    input  switch, confirm_btn, eng_busy, eng_done, eng_result,
    output eng_start, eng_data, entry_count, disp_value, disp_index,
           disp_valid, busy, error
  );

  modport slave (
    output switch, confirm_btn, eng_busy, eng_done, eng_result,
    input  eng_start, eng_data, entry_count, disp_value, disp_index,
           disp_valid, busy, error
  );
endinterface

// File: rtl/sort_ctrl.sv
// ---------------------------------------------------------------------------
// sort_ctrl
//   Front-end sequencer for the nibble sort engine. Debounces the confirm
//   button (2-FF synchroniser + rising-edge detect), collects N switch
//   values, launches the engine with a start/busy/done handshake guarded by
//   a timeout, then scrolls the sorted result onto the display path.
//
//   Ports:
//     clk  system clock
//     rst  asynchronous reset, active-high
//     bus  sort_ctrl_if master modport (switch/button, engine handshake,
//          display and status outputs)
// ---------------------------------------------------------------------------
module sort_ctrl #(
  parameter int N          = 5,
  parameter int W          = 4,
  parameter int DISP_TICKS = 50_000_000,
  parameter int TIMEOUT    = 1024
) (
  input logic         clk,
  input logic         rst,
  sort_ctrl_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int TK_W = (DISP_TICKS > 1) ? $clog2(DISP_TICKS) : 1;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_LAUNCH,
    S_WAIT,
    S_SHOW,
    S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      sync_q;
  logic            cpulse;
  logic [2:0]      entryCount_q, entryCount_d;
  logic [N*W-1:0]  valueBuf_q, valueBuf_d;
  logic [N*W-1:0]  result_q, result_d;
  logic [TO_W-1:0] timeoutCnt_q, timeoutCnt_d;
  logic [TK_W-1:0] tick_q, tick_d;
  logic [2:0]      dispIndex_q, dispIndex_d;
  logic [W-1:0]    dispValue_q;
  logic [W-1:0]    dispSel;
  logic            engStart;

  // Two synchroniser stages plus one history stage for edge detection; the
  // pulse is high in the cycle ending with the 3rd edge after the press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], bus.confirm_btn};
  end

  assign cpulse = sync_q[1] & ~sync_q[2];

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_COLLECT;
      entryCount_q <= '0;
      valueBuf_q   <= '0;
      result_q     <= '0;
      timeoutCnt_q <= '0;
      tick_q       <= '0;
      dispIndex_q  <= '0;
    end else begin
      state_q      <= state_d;
      entryCount_q <= entryCount_d;
      valueBuf_q   <= valueBuf_d;
      result_q     <= result_d;
      timeoutCnt_q <= timeoutCnt_d;
      tick_q       <= tick_d;
      dispIndex_q  <= dispIndex_d;
    end
  end

  // Next-state and datapath update; cpulse is simply not consumed in
  // LAUNCH/WAIT, and eng_done is only looked at in WAIT.
  always_comb begin
    state_d      = state_q;
    entryCount_d = entryCount_q;
    valueBuf_d   = valueBuf_q;
    result_d     = result_q;
    timeoutCnt_d = timeoutCnt_q;
    tick_d       = tick_q;
    dispIndex_d  = dispIndex_q;
    engStart     = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (cpulse && (entryCount_q < 3'(N))) begin
          for (int k = 0; k < N; k++) begin
            if (entryCount_q == 3'(k)) valueBuf_d[k*W +: W] = bus.switch;
          end
          entryCount_d = entryCount_q + 3'd1;
          if (entryCount_q == 3'(N - 1)) state_d = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        if (!bus.eng_busy) begin
          engStart     = 1'b1;
          timeoutCnt_d = '0;
          state_d      = S_WAIT;
        end
      end

      S_WAIT: begin
        timeoutCnt_d = timeoutCnt_q + 1'b1;
        // A done arriving in the timeout cycle still counts as success.
        if (bus.eng_done) begin
          result_d    = bus.eng_result;
          dispIndex_d = '0;
          tick_d      = '0;
          state_d     = S_SHOW;
        end else if (timeoutCnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end
      end

      S_SHOW: begin
        if (cpulse) begin
          entryCount_d = '0;
          valueBuf_d   = '0;
          dispIndex_d  = '0;
          tick_d       = '0;
          state_d      = S_COLLECT;
        end else if (tick_q == TK_W'(DISP_TICKS - 1)) begin
          tick_d      = '0;
          dispIndex_d = (dispIndex_q == 3'(N - 1)) ? 3'd0 : dispIndex_q + 3'd1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      S_FAULT: begin
        if (cpulse) begin
          entryCount_d = '0;
          valueBuf_d   = '0;
          state_d      = S_COLLECT;
        end
      end

      default: state_d = S_COLLECT;
    endcase
  end

  // Select the result nibble addressed by the current display index.
  always_comb begin
    dispSel = '0;
    for (int k = 0; k < N; k++) begin
      if (dispIndex_q == 3'(k)) dispSel = result_q[k*W +: W];
    end
  end

  // Displayed nibble is registered, so it trails the index by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    dispValue_q <= '0;
    else if (state_q == S_SHOW) dispValue_q <= dispSel;
    else                        dispValue_q <= '0;
  end

  assign bus.eng_start   = engStart;
  assign bus.eng_data    = valueBuf_q;
  assign bus.entry_count = entryCount_q;
  assign bus.disp_value  = dispValue_q;
  assign bus.disp_index  = dispIndex_q;
  assign bus.disp_valid  = (state_q == S_SHOW);
  assign bus.busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT);
  assign bus.error       = (state_q == S_FAULT);

endmodule

// File: doc/sort_ctrl.md
Name: sort_ctrl

Overview:
- Front-end sequencer for the 5-entry nibble sort engine on the lab board.
- Takes a raw push-button confirm and debounces it by synchronising and edge-detecting it.
- Collects N switch values, launches the sort engine through a start/busy/done handshake, and guards the engine with a timeout.
- Scrolls the sorted result one nibble at a time to the 7-segment display path.

Parameters:
- N, 5, number of values collected per sort job (2..7).
- W, 4, bit width of each value.
- DISP_TICKS, 50_000_000, clk cycles each result nibble stays on the display (>=1).
- TIMEOUT, 1024, max clk cycles to wait for eng_done after eng_start (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- switch  in  W  value to enter; sampled on a confirm edge.
- confirm_btn  in  1  raw asynchronous button, active-high.
- eng_busy  in  1  engine busy; start must not be issued while high.
- eng_done  in  1  one-cycle pulse, result valid.
- eng_result  in  N*W  sorted values; entry k is at [k*W +: W], ascending from k=0.
- eng_start  out  1  one-cycle start pulse.
- eng_data  out  N*W  packed inputs; entry k (k-th confirmed) is at [k*W +: W].
- entry_count  out  3  values entered so far, 0..N.
- disp_value  out  W  nibble currently displayed.
- disp_index  out  3  index of the displayed nibble.
- disp_valid  out  1  high in SHOW.
- busy  out  1  high in LAUNCH or WAIT.
- error  out  1  high in FAULT.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- All outputs reset to 0.
- Value buffer, result register, counters and sync flops reset to 0; state resets to COLLECT.
- Reset mid-job (any state) aborts immediately; eng_start is never left high.
- Confirm path:
  - 2-FF synchroniser, then a rising-edge detect produces cpulse, exactly one cycle per press.
  - Holding the button produces no further pulses.
  - cpulse is asserted during the 3rd clk edge after confirm_btn rises (setup met); switch is sampled on that edge.
- State COLLECT:
  - On cpulse: buf[entry_count] <= switch, entry_count += 1.
  - When the pulse makes entry_count == N, go to LAUNCH.
- State LAUNCH:
  - If eng_busy == 0: drive eng_start = 1 for exactly that cycle, clear the timeout counter, go to WAIT.
  - Otherwise stay in LAUNCH with eng_start = 0.
  - eng_data always presents the packed buffer, held stable from LAUNCH until leaving WAIT.
- State WAIT:
  - Timeout counter increments each cycle.
  - On eng_done: latch eng_result and go to SHOW with disp_index = 0 and the tick counter = 0.
  - If the counter reaches TIMEOUT without eng_done: go to FAULT.
  - If eng_done and the timeout occur in the same cycle, eng_done wins.
- State SHOW:
  - disp_valid = 1; disp_value = result[disp_index*W +: W], registered (1-cycle latency from the index update).
  - Every DISP_TICKS cycles disp_index increments, wrapping N-1 -> 0.
  - On cpulse: clear entry_count and the buffer, disp_valid = 0, go to COLLECT. The switch value at that press is NOT stored.
- State FAULT:
  - error = 1.
  - On cpulse: clear error, entry_count and the buffer, go to COLLECT.
- cpulse in LAUNCH or WAIT is ignored and dropped.
- eng_done outside WAIT is ignored.
- entry_count never exceeds N; it is cleared only on the COLLECT re-entry paths above.

Test Plan (N=5, W=4, DISP_TICKS=4, TIMEOUT=20; engine model sorts in 12 cycles):
- Press confirm 5x with switch = 9,3,F,0,3 -> eng_start pulses once; eng_data = 0x30F39; eng_done arrives 12 cycles later; disp_value cycles 0,3,3,9,F, each held 4 cycles, then wraps to 0.
- Hold confirm_btn high for 50 cycles with switch = 7 -> entry_count goes 0->1 only; buf[0] = 7.
- eng_busy held high for 10 cycles at LAUNCH -> eng_start stays low until the first cycle eng_busy = 0, then a single 1-cycle pulse; busy = 1 throughout.
- Model never asserts eng_done -> 20 cycles after eng_start, error = 1 and busy = 0; next press -> error = 0, entry_count = 0, state COLLECT.
- Presses during WAIT -> ignored; entry_count stays 5 and the result is unchanged. A press in SHOW -> entry_count = 0, disp_valid = 0, switch value not stored.
- Assert rst during WAIT -> all outputs 0 immediately; a late eng_done after reset is ignored; a new 5-entry job then completes normally.
